// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised serial input, centre-sampled start/data/stop
// bits driven by a bit-width down-counter, a bit counter and a single FSM.
module uart_rx #(
  parameter int WIDTH = 8,
  parameter int FCLK  = 50000000,
  parameter int BAUD  = 115200
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_i,
  output logic [WIDTH-1:0] data_o,
  output logic             rx_done_o,
  output logic             frame_err_o,
  output logic             idle_o
);

  localparam int CLKS = FCLK / BAUD;
  localparam int HALF = CLKS / 2;
  localparam int CW   = (CLKS > 1) ? $clog2(CLKS) : 1;
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (CLKS < 4) begin : g_bad_clks
      $error("uart_rx: FCLK/BAUD must be at least 4");
    end
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("uart_rx: WIDTH must be in 1..16");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d, shift_in;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             tick;

  assign tick = (cnt_q == '0);

  // New bit enters at the MSB so the first bit received ends up in bit 0.
  generate
    if (WIDTH == 1) begin : g_shift_one
      assign shift_in = rx_s_q;
    end else begin : g_shift_many
      assign shift_in = {rx_s_q, shift_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = CW'(HALF - 1);
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rx_s_q) begin
            cnt_d   = CW'(CLKS - 1);
            bit_d   = '0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_in;
          cnt_d   = CW'(CLKS - 1);
          if (bit_q == BW'(WIDTH - 1)) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        // Leaving at mid-stop lets a start bit follow the stop bit with no gap.
        if (tick) begin
          if (rx_s_q) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign data_o      = data_q;
  assign rx_done_o   = done_q;
  assign frame_err_o = ferr_q;
  assign idle_o      = (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx: a serial line driver plus a
// frame-level reference model of what should be received.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       rx_i = 1'b1;
  logic [7:0] data_o;
  logic       rx_done_o, frame_err_o, idle_o;

  logic       rx_d = 1'b1;
  logic [7:0] d_data_o;
  logic       d_done_o, d_ferr_o, d_idle_o;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx #(.WIDTH(8), .FCLK(1000000), .BAUD(100000)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i),
    .data_o(data_o), .rx_done_o(rx_done_o), .frame_err_o(frame_err_o), .idle_o(idle_o)
  );

  uart_rx u_dflt (
    .clk_i(clk), .rst_i(rst_i), .rx_i(rx_d),
    .data_o(d_data_o), .rx_done_o(d_done_o), .frame_err_o(d_ferr_o), .idle_o(d_idle_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed events
  logic [7:0] got_q[$];
  int         got_t[$];
  int         ferr_cnt  = 0;
  int         both_cnt  = 0;
  int         dflt_done = 0;

  always @(negedge clk) begin
    if (rx_done_o) begin
      got_q.push_back(data_o);
      got_t.push_back(cyc);
    end
    if (frame_err_o) ferr_cnt++;
    if (rx_done_o && frame_err_o) both_cnt++;
    if (d_done_o) dflt_done++;
  end

  // Reference model: frames that should complete and what data_o should hold
  logic [7:0] model_data = 8'h00;
  int         exp_done   = 0;
  int         exp_ferr   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n, input bit sel_d);
    if (sel_d) rx_d = v;
    else       rx_i = v;
    repeat (n) @(negedge clk);
  endtask

  // Bit index k (0=start, 1..8 data, 9=stop) lasts pe clocks if k even, po if odd.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int pe, input int po,
                            input bit sel_d, output int t_edge);
    t_edge = cyc + 1;
    drive(1'b0, pe, sel_d);
    for (int i = 0; i < 8; i++) drive(d[i], ((i + 1) % 2 == 0) ? pe : po, sel_d);
    drive(stop, po, sel_d);
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (got_q.size() < n) check_eq("done_timeout", got_q.size(), n);
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_ndone"}, got_q.size(), exp_done);
    check_eq({tag, "_nferr"}, ferr_cnt, exp_ferr);
    check_eq({tag, "_data"}, data_o, model_data);
    check_eq({tag, "_idle"}, idle_o, 1'b1);
  endtask

  // Good or bad frame followed by gap clocks of idle line; checked against the model.
  task automatic run_frame(input logic [7:0] d, input logic stop, input int pe, input int po,
                           input int gap, input string tag);
    int t;
    send_frame(d, stop, pe, po, 1'b0, t);
    rx_i = 1'b1;
    if (stop) begin
      exp_done++;
      model_data = d;
      wait_done(exp_done, 50);
      if (got_q.size() >= exp_done) check_eq({tag, "_word"}, got_q[exp_done-1], d);
    end else begin
      exp_ferr++;
    end
    repeat (gap) @(negedge clk);
    check_state(tag);
    $display("[TB] %s frame 0x%02h stop=%0d bits=%0d/%0d -> data_o=0x%02h", tag, d, stop, pe, po, data_o);
  endtask

  initial begin
    int t, b, lat;
    logic [7:0] rd;
    logic       rs;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_data", data_o, 8'h00);
    check_eq("rst_done", rx_done_o, 1'b0);
    check_eq("rst_ferr", frame_err_o, 1'b0);
    check_eq("rst_idle", idle_o, 1'b1);
    rst_i = 1'b0;
    repeat (5) @(negedge clk);

    // 1: single frame, latency from rx_i start edge
    b = got_q.size();
    send_frame(8'hA5, 1'b1, 10, 10, 1'b0, t);
    exp_done++;
    model_data = 8'hA5;
    wait_done(exp_done, 50);
    if (got_q.size() > b) begin
      lat = got_t[b] - t;
      check_eq("t1_latency", lat, 2 + 5 + 9 * 10);
    end
    repeat (5) @(negedge clk);
    check_state("t1");
    $display("[TB] t1 frame 0xa5 -> data_o=0x%02h", data_o);

    // 2: back-to-back frames, no idle gap
    b = got_q.size();
    send_frame(8'h00, 1'b1, 10, 10, 1'b0, t);
    send_frame(8'hFF, 1'b1, 10, 10, 1'b0, t);
    send_frame(8'h3C, 1'b1, 10, 10, 1'b0, t);
    exp_done += 3;
    model_data = 8'h3C;
    wait_done(exp_done, 50);
    if (got_q.size() >= b + 3) begin
      check_eq("t2_w0", got_q[b], 8'h00);
      check_eq("t2_w1", got_q[b+1], 8'hFF);
      check_eq("t2_w2", got_q[b+2], 8'h3C);
      check_eq("t2_gap01", got_t[b+1] - got_t[b], 100);
      check_eq("t2_gap12", got_t[b+2] - got_t[b+1], 100);
    end
    repeat (5) @(negedge clk);
    check_state("t2");
    $display("[TB] t2 frames 0x00 0xff 0x3c back-to-back -> data_o=0x%02h", data_o);

    // 3: glitch shorter than half a bit
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    repeat (30) @(negedge clk);
    check_state("t3");
    $display("[TB] t3 glitch 3 clk -> data_o=0x%02h idle=%0d", data_o, idle_o);

    // 4: bad stop bit, then held break, then a good frame
    send_frame(8'h55, 1'b0, 10, 10, 1'b0, t);
    exp_ferr++;
    repeat (50) @(negedge clk);
    rx_i = 1'b1;
    repeat (10) @(negedge clk);
    check_state("t4_break");
    check_eq("t4_both", both_cnt, 0);
    $display("[TB] t4 frame 0x55 stop=0 + break -> frame errors=%0d", ferr_cnt);
    run_frame(8'h12, 1'b1, 10, 10, 5, "t4_next");

    // 5: reset in the middle of data bit 4
    rd = 8'($urandom);
    rx_i = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) drive(rd[i], 10, 1'b0);
    drive(rd[4], 5, 1'b0);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    rx_i = 1'b1;
    model_data = 8'h00;
    check_eq("t5_rst_data", data_o, 8'h00);
    check_eq("t5_rst_done", rx_done_o, 1'b0);
    check_eq("t5_rst_ferr", frame_err_o, 1'b0);
    check_eq("t5_rst_idle", idle_o, 1'b1);
    repeat (120) @(negedge clk);
    check_state("t5_abort");
    $display("[TB] t5 reset mid-frame (0x%02h) -> data_o=0x%02h", rd, data_o);
    run_frame(8'h81, 1'b1, 10, 10, 5, "t5_next");

    // 6: bit periods alternating between 9 and 11 clocks
    run_frame(8'hC3, 1'b1, 9, 11, 5, "t6_9_11");
    run_frame(8'hC3, 1'b1, 11, 9, 5, "t6_11_9");

    // Random frames, occasional bad stop bit, random idle gaps
    for (int n = 0; n < 16; n++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      run_frame(rd, rs, 10, 10, rs ? $urandom_range(0, 12) : $urandom_range(2, 12), "rnd");
    end
    check_eq("never_both", both_cnt, 0);

    // Default-parameter receiver driven at its own bit period
    send_frame(8'h5A, 1'b1, 434, 434, 1'b1, t);
    rx_d = 1'b1;
    for (int k = 0; k < 1000 && dflt_done < 1; k++) @(negedge clk);
    check_eq("dflt_ndone", dflt_done, 1);
    check_eq("dflt_data", d_data_o, 8'h5A);
    check_eq("dflt_ferr", d_ferr_o, 1'b0);
    $display("[TB] default-parameter frame 0x5a -> data_o=0x%02h", d_data_o);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
